preadder_issue: RTL

- Operand issue stage directly upstream of the N-thread pre-adder.
- Accepts per-thread pre-add commands and reads both operands from the operand RAM (dual read port, fixed latency).
- Presents X, Y and mode to the pre-adder in a strict round-robin slot schedule (slot s always carries thread s), which the pre-adder's N_THREADS-deep delay lines rely on.
- Also detects illegal accumulate chains.

---
 rtl/preadder_issue_pkg.sv | 24 ++
 rtl/issue_delay_line.sv | 41 ++++
 rtl/preadder_issue.sv | 129 ++++++++++++
 3 files changed

// File: rtl/preadder_issue_pkg.sv
// Shared types for the pre-adder operand issue stage: operand word layout,
// thread count, pre-adder mode encodings and the pending-command record.
package preadder_issue_pkg;

    localparam int unsigned N_THREADS  = 4;
    localparam int unsigned LIMB_W     = 20;
    localparam int unsigned POLY_LIMBS = 3;
    localparam int unsigned CMD_ADDR_W = 6;

    typedef logic [POLY_LIMBS-1:0][LIMB_W-1:0] redundant_poly_L3;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_ADDSUB = 2'b01,
        MODE_ACC    = 2'b10
    } preadd_mode_e;

    typedef struct packed {
        preadd_mode_e          mode;
        logic [CMD_ADDR_W-1:0] addr_x;
        logic [CMD_ADDR_W-1:0] addr_y;
    } issue_cmd_t;

endpackage

// File: rtl/issue_delay_line.sv
// Fixed-depth shift pipeline keeping slot side-band aligned with RAM read data.
// Only the valid bits are reset; payload follows whatever was shifted in.
module issue_delay_line #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         vld [DEPTH];
    logic [W-1:0] dat [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                vld[i] <= 1'b0;
            end
        end else begin
            vld[0] <= in_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dat[0] <= in_data;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            dat[i] <= dat[i-1];
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/preadder_issue.sv
// Round-robin operand issue stage: one pending command per thread, slot s always
// carries thread s, operands fetched from a fixed-latency dual-port RAM.
module preadder_issue
    import preadder_issue_pkg::*;
#(
    parameter int unsigned N_THREADS = preadder_issue_pkg::N_THREADS,
    parameter int unsigned ADDR_W    = CMD_ADDR_W,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned TID_W     = $clog2(N_THREADS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [TID_W-1:0] cmd_thread,
    input  logic [1:0]       cmd_mode,
    input  logic [ADDR_W-1:0] cmd_addr_x,
    input  logic [ADDR_W-1:0] cmd_addr_y,
    output logic             rd_en,
    output logic [ADDR_W-1:0] rd_addr_x,
    output logic [ADDR_W-1:0] rd_addr_y,
    input  redundant_poly_L3 rd_data_x,
    input  redundant_poly_L3 rd_data_y,
    output redundant_poly_L3 X,
    output redundant_poly_L3 Y,
    output logic [1:0]       mode,
    output logic             out_valid,
    output logic [TID_W-1:0] out_thread,
    output logic             chain_err
);

    localparam int unsigned SIDE_W = 2 + TID_W;

    logic [TID_W-1:0]     slot;
    logic [N_THREADS-1:0] pending;
    issue_cmd_t           entry [N_THREADS];
    logic [N_THREADS-1:0] last_valid;
    logic [ADDR_W-1:0]    addr_x_q;
    logic [ADDR_W-1:0]    addr_y_q;

    logic                 issue;
    issue_cmd_t           issue_cmd;
    logic                 accept;

    logic [SIDE_W-1:0]    side_in;
    logic [SIDE_W-1:0]    side_out;
    logic                 pipe_valid;
    preadd_mode_e         pipe_mode;
    logic [TID_W-1:0]     pipe_thread;

    assign cmd_ready = !pending[cmd_thread];
    assign accept    = cmd_valid && cmd_ready;

    assign issue     = pending[slot];
    assign issue_cmd = entry[slot];

    // Read strobe is combinational on the slot so RAM data lands RD_LAT later,
    // keeping issue-to-output at exactly RD_LAT+1 cycles.
    assign rd_en     = issue;
    assign rd_addr_x = issue ? issue_cmd.addr_x : addr_x_q;
    assign rd_addr_y = issue ? issue_cmd.addr_y : addr_y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot     <= '0;
            pending  <= '0;
            addr_x_q <= '0;
            addr_y_q <= '0;
        end else begin
            slot <= (slot == TID_W'(N_THREADS - 1)) ? '0 : slot + 1'b1;
            if (issue) begin
                pending[slot] <= 1'b0;
                addr_x_q      <= issue_cmd.addr_x;
                addr_y_q      <= issue_cmd.addr_y;
            end
            // A thread being issued has cmd_ready low, so set and clear never collide.
            if (accept) begin
                pending[cmd_thread] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            entry[cmd_thread] <= '{mode:   preadd_mode_e'(cmd_mode),
                                   addr_x: cmd_addr_x,
                                   addr_y: cmd_addr_y};
        end
    end

    assign side_in = {issue_cmd.mode, slot};

    issue_delay_line #(
        .DEPTH (RD_LAT),
        .W     (SIDE_W)
    ) u_side (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_data   (side_in),
        .out_valid (pipe_valid),
        .out_data  (side_out)
    );

    assign pipe_mode   = preadd_mode_e'(side_out[TID_W +: 2]);
    assign pipe_thread = side_out[TID_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            X          <= '0;
            Y          <= '0;
            mode       <= MODE_PASS;
            out_valid  <= 1'b0;
            out_thread <= '0;
            chain_err  <= 1'b0;
            last_valid <= '0;
        end else begin
            X          <= pipe_valid ? rd_data_x : '0;
            Y          <= pipe_valid ? rd_data_y : '0;
            mode       <= pipe_valid ? pipe_mode : MODE_PASS;
            out_valid  <= pipe_valid;
            out_thread <= pipe_thread;
            // Accumulate needs the same thread to have been live one round earlier.
            chain_err  <= pipe_valid && (pipe_mode == MODE_ACC) && !last_valid[pipe_thread];
            last_valid[pipe_thread] <= pipe_valid;
        end
    end

endmodule
